mem_wb_stage: RTL and testbench

- MEM/WB pipeline register for the 5-stage core. It sits directly upstream of the write-back select mux.
- Captures the MEM-stage results and performs load byte/halfword extraction and sign/zero extension on the raw data-memory word.
- Presents registered pc, ALU result, extended load data and wbSel to the write-back mux.
- Also produces the gated register-file write enable, a misaligned-load flag, and a 64-bit retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 23 ++
 rtl/mem_wb_stage_load_ext.sv | 43 ++++
 rtl/mem_wb_stage.sv | 103 ++++++++++
 tb/tb_mem_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB boundary: write-back select codes and load funct3 values.
// Imported by the MEM/WB register, the load extractor and the write-back mux.
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_PC4      = 2'b00;
  localparam logic [1:0] WB_FROM_ALU = 2'b01;
  localparam logic [1:0] WB_FROM_DM  = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load extractor: picks the addressed byte/halfword out of an aligned word,
// extends it, and reports natural-alignment violations for the given load type.
module load_ext
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  w_bytes  [4];
  logic [15:0] w_halves [2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_bytes[gi] = word[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign w_halves[gi] = word[16*gi +: 16];
  end

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (ld_type)
      LD_LB:  data = ext8(w_bytes[off], 1'b1);
      LD_LBU: data = ext8(w_bytes[off], 1'b0);
      LD_LH: begin
        data       = ext16(w_halves[off[1]], 1'b1);
        misaligned = off[0];
      end
      LD_LHU: begin
        data       = ext16(w_halves[off[1]], 1'b0);
        misaligned = off[0];
      end
      LD_LW:  misaligned = |off;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: registers MEM results, extends load data, gates the
// register-file write enable and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [XLEN-1:0]      mem_pc,
  input  logic [XLEN-1:0]      mem_alu,
  input  logic [XLEN-1:0]      mem_dm_word,
  input  logic [2:0]           mem_ld_type,
  input  logic [1:0]           mem_wbSel,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_rf_we,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_pc,
  output logic [XLEN-1:0]      wb_alu,
  output logic [XLEN-1:0]      wb_dm,
  output logic [1:0]           wb_wbSel,
  output logic [4:0]           wb_rd,
  output logic                 wb_rf_we,
  output logic                 wb_misalign,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  logic                 r_valid;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_alu;
  logic [XLEN-1:0]      r_dm;
  logic [1:0]           r_wbsel;
  logic [4:0]           r_rd;
  logic                 r_rf_we;
  logic                 r_misalign;
  logic [INSTRET_W-1:0] r_instret;

  logic [31:0] w_ext_data;
  logic        w_ext_misaligned;
  logic        w_misaligned;
  logic        w_rf_we;
  logic        w_retire;

  load_ext u_load_ext (
    .word       (mem_dm_word),
    .off        (mem_alu[1:0]),
    .ld_type    (mem_ld_type),
    .data       (w_ext_data),
    .misaligned (w_ext_misaligned)
  );

  // Alignment only matters for real loads; other ops may carry any low address bits.
  assign w_misaligned = mem_valid & (mem_wbSel == WB_FROM_DM) & w_ext_misaligned;
  assign w_rf_we      = mem_valid & mem_rf_we & (|mem_rd) & ~w_misaligned;
  assign w_retire     = mem_valid & ~w_misaligned;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_alu      <= '0;
      r_dm       <= '0;
      r_wbsel    <= '0;
      r_rd       <= '0;
      r_rf_we    <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      r_valid    <= mem_valid;
      r_pc       <= mem_pc;
      r_alu      <= mem_alu;
      r_dm       <= w_ext_data;
      r_wbsel    <= mem_wbSel;
      r_rd       <= mem_rd;
      r_rf_we    <= w_rf_we;
      r_misalign <= w_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (!flush && !stall && w_retire) begin
      r_instret <= r_instret + INSTRET_ONE;
    end
  end

  assign wb_valid    = r_valid;
  assign wb_pc       = r_pc;
  assign wb_alu      = r_alu;
  assign wb_dm       = r_dm;
  assign wb_wbSel    = r_wbsel;
  assign wb_rd       = r_rd;
  assign wb_rf_we    = r_rf_we;
  assign wb_misalign = r_misalign;
  assign instret     = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second narrow-counter instance exercises wrap.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_valid, mem_rf_we;
  logic [31:0] mem_pc, mem_alu, mem_dm_word;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_wbSel;
  logic [4:0]  mem_rd;

  logic        wb_valid, wb_rf_we, wb_misalign;
  logic [31:0] wb_pc, wb_alu, wb_dm;
  logic [1:0]  wb_wbSel;
  logic [4:0]  wb_rd;
  logic [63:0] instret;

  logic        n_valid, n_rf_we, n_misalign;
  logic [31:0] n_pc, n_alu, n_dm;
  logic [1:0]  n_wbsel;
  logic [4:0]  n_rd;
  logic [2:0]  n_instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_pc(mem_pc), .mem_alu(mem_alu), .mem_dm_word(mem_dm_word),
    .mem_ld_type(mem_ld_type), .mem_wbSel(mem_wbSel), .mem_rd(mem_rd),
    .mem_rf_we(mem_rf_we), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu(wb_alu),
    .wb_dm(wb_dm), .wb_wbSel(wb_wbSel), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we),
    .wb_misalign(wb_misalign), .instret(instret)
  );

  mem_wb_stage #(.XLEN(32), .INSTRET_W(3)) dut_narrow (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_pc(mem_pc), .mem_alu(mem_alu), .mem_dm_word(mem_dm_word),
    .mem_ld_type(mem_ld_type), .mem_wbSel(mem_wbSel), .mem_rd(mem_rd),
    .mem_rf_we(mem_rf_we), .wb_valid(n_valid), .wb_pc(n_pc), .wb_alu(n_alu),
    .wb_dm(n_dm), .wb_wbSel(n_wbsel), .wb_rd(n_rd), .wb_rf_we(n_rf_we),
    .wb_misalign(n_misalign), .instret(n_instret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] word, input logic [2:0] lt, input logic [1:0] sel,
                       input logic [4:0] rd, input logic we);
    mem_valid = v; mem_pc = pc; mem_alu = alu; mem_dm_word = word;
    mem_ld_type = lt; mem_wbSel = sel; mem_rd = rd; mem_rf_we = we;
  endtask

  task automatic randomize_inputs();
    drive(1'($urandom), $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom),
          5'($urandom), 1'($urandom));
  endtask

  logic [31:0] lb_exp [4];

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    randomize_inputs();
    #2;

    // Reset with random inputs for two edges
    step(); randomize_inputs(); stall = 1'($urandom);
    step();
    check("rst_valid", 64'(wb_valid), 64'h0);
    check("rst_pc", 64'(wb_pc), 64'h0);
    check("rst_alu", 64'(wb_alu), 64'h0);
    check("rst_dm", 64'(wb_dm), 64'h0);
    check("rst_wbsel", 64'(wb_wbSel), 64'h0);
    check("rst_rd", 64'(wb_rd), 64'h0);
    check("rst_rf_we", 64'(wb_rf_we), 64'h0);
    check("rst_misalign", 64'(wb_misalign), 64'h0);
    check("rst_instret", instret, 64'h0);

    // First ALU instruction after release
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 32'h40, 32'h1234, 32'hDEAD_BEEF, LD_LW, WB_FROM_ALU, 5'd5, 1'b1);
    step();
    check("alu_wb_alu", 64'(wb_alu), 64'h1234);
    check("alu_rf_we", 64'(wb_rf_we), 64'h1);
    check("alu_valid", 64'(wb_valid), 64'h1);
    check("alu_rd", 64'(wb_rd), 64'd5);
    check("alu_wbsel", 64'(wb_wbSel), 64'(WB_FROM_ALU));
    check("alu_instret", instret, 64'd1);

    // Signed byte loads at every offset
    lb_exp[0] = 32'h0000_0001; lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF; lb_exp[3] = 32'hFFFF_FF80;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h44, 32'h2000 + 32'(i), 32'h80FF_7F01, LD_LB, WB_FROM_DM, 5'd6, 1'b1);
      step();
      check($sformatf("lb_off%0d", i), 64'(wb_dm), 64'(lb_exp[i]));
      check($sformatf("lb_off%0d_misalign", i), 64'(wb_misalign), 64'h0);
    end
    check("lb_instret", instret, 64'd5);

    drive(1'b1, 32'h48, 32'h2003, 32'h80FF_7F01, LD_LBU, WB_FROM_DM, 5'd6, 1'b1);
    step();
    check("lbu_off3", 64'(wb_dm), 64'h80);

    // Halfword loads
    drive(1'b1, 32'h4C, 32'h2000, 32'h8001_7FFF, LD_LH, WB_FROM_DM, 5'd7, 1'b1);
    step();
    check("lh_off0", 64'(wb_dm), 64'h7FFF);
    drive(1'b1, 32'h50, 32'h2002, 32'h8001_7FFF, LD_LH, WB_FROM_DM, 5'd7, 1'b1);
    step();
    check("lh_off2", 64'(wb_dm), 64'hFFFF_8001);
    drive(1'b1, 32'h54, 32'h2002, 32'h8001_7FFF, LD_LHU, WB_FROM_DM, 5'd7, 1'b1);
    step();
    check("lhu_off2", 64'(wb_dm), 64'h8001);
    check("lhu_rf_we", 64'(wb_rf_we), 64'h1);
    check("lhu_instret", instret, 64'd9);

    // Misaligned loads: no write, no retire
    drive(1'b1, 32'h58, 32'h2002, 32'h8001_7FFF, LD_LW, WB_FROM_DM, 5'd7, 1'b1);
    step();
    check("lw_off2_misalign", 64'(wb_misalign), 64'h1);
    check("lw_off2_rf_we", 64'(wb_rf_we), 64'h0);
    check("lw_off2_valid", 64'(wb_valid), 64'h1);
    check("lw_off2_instret", instret, 64'd9);
    drive(1'b1, 32'h5C, 32'h2001, 32'h8001_7FFF, LD_LHU, WB_FROM_DM, 5'd7, 1'b1);
    step();
    check("lhu_off1_misalign", 64'(wb_misalign), 64'h1);
    check("lhu_off1_instret", instret, 64'd9);

    // Misalignment is not raised for non-load write-back sources
    drive(1'b1, 32'h60, 32'h2002, 32'h0, LD_LW, WB_FROM_ALU, 5'd8, 1'b1);
    step();
    check("alu_lowbits_misalign", 64'(wb_misalign), 64'h0);
    check("alu_lowbits_rf_we", 64'(wb_rf_we), 64'h1);
    check("alu_lowbits_instret", instret, 64'd10);

    // Stall holds everything while inputs change
    drive(1'b1, 32'h64, 32'h3000, 32'hCAFE_BABE, LD_LW, WB_FROM_DM, 5'd9, 1'b1);
    step();
    check("pre_stall_dm", 64'(wb_dm), 64'hCAFE_BABE);
    check("pre_stall_instret", instret, 64'd11);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h4000 + 32'(4*i), 32'h1111_1111 * 32'(i + 1),
            LD_LB, WB_FROM_ALU, 5'd10 + 5'(i), 1'b1);
      step();
      check($sformatf("stall%0d_dm", i), 64'(wb_dm), 64'hCAFE_BABE);
      check($sformatf("stall%0d_alu", i), 64'(wb_alu), 64'h3000);
      check($sformatf("stall%0d_rd", i), 64'(wb_rd), 64'd9);
      check($sformatf("stall%0d_instret", i), instret, 64'd11);
    end

    // Flush wins over stall
    flush = 1'b1;
    step();
    check("flush_valid", 64'(wb_valid), 64'h0);
    check("flush_rf_we", 64'(wb_rf_we), 64'h0);
    check("flush_alu", 64'(wb_alu), 64'h0);
    check("flush_instret", instret, 64'd11);
    flush = 1'b0; stall = 1'b0;

    // x0 destination: retires but never writes
    drive(1'b1, 32'h68, 32'h55, 32'h0, LD_LW, WB_FROM_ALU, 5'd0, 1'b1);
    step();
    check("x0_rf_we", 64'(wb_rf_we), 64'h0);
    check("x0_instret", instret, 64'd12);

    // PC+4 source, pc forwarded
    drive(1'b1, 32'h100, 32'h0, 32'h0, LD_LW, WB_PC4, 5'd1, 1'b1);
    step();
    check("pc4_pc", 64'(wb_pc), 64'h100);
    check("pc4_wbsel", 64'(wb_wbSel), 64'(WB_PC4));
    check("pc4_instret", instret, 64'd13);

    // Illegal wbSel forwarded as-is
    drive(1'b1, 32'h104, 32'h0, 32'h0, LD_LW, 2'b11, 5'd2, 1'b1);
    step();
    check("wbsel_illegal", 64'(wb_wbSel), 64'h3);

    // Bubble capture: no retire, no write
    drive(1'b0, 32'h108, 32'h2002, 32'h0, LD_LW, WB_FROM_DM, 5'd3, 1'b1);
    step();
    check("bubble_valid", 64'(wb_valid), 64'h0);
    check("bubble_rf_we", 64'(wb_rf_we), 64'h0);
    check("bubble_misalign", 64'(wb_misalign), 64'h0);
    check("bubble_instret", instret, 64'd14);

    // Reset during stall clears state
    drive(1'b1, 32'h10C, 32'h77, 32'h0, LD_LW, WB_FROM_ALU, 5'd4, 1'b1);
    stall = 1'b1; rst = 1'b1;
    step();
    check("rst_stall_alu", 64'(wb_alu), 64'h0);
    check("rst_stall_valid", 64'(wb_valid), 64'h0);
    check("rst_stall_instret", instret, 64'h0);
    stall = 1'b0; rst = 1'b0;

    // Counter wrap on the narrow instance: 7 then 0
    drive(1'b1, 32'h200, 32'h0, 32'h0, LD_LW, WB_FROM_ALU, 5'd5, 1'b1);
    for (int i = 0; i < 7; i++) step();
    check("narrow_instret_max", 64'(n_instret), 64'd7);
    step();
    check("narrow_instret_wrap", 64'(n_instret), 64'd0);
    check("wide_instret_8", instret, 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
